el2_exu_custom_opbuf: RTL and testbench
=======================================

Name: el2_exu_custom_opbuf

Overview:
Parametrised, double-buffered operand loader for multi-beat custom instructions in the EXU. Each beat captures {rs2_in, rs1_in} into an operand bank. A completed load sequence commits the bank to a 2-entry queue that feeds the custom compute engine over a valid/ready handshake. The next operand set can load while the engine consumes the previous one. Sequence, overflow and full-queue errors are reported through sticky flags.

Parameters:
XLEN, 32, width of rs1_in/rs2_in; one beat = 2*XLEN bits
NBEATS, 7, maximum beats per operand set (bank width = NBEATS*2*XLEN)
IDXW, $clog2(NBEATS+1), width of beat index and beat count

Ports:
clk  in  1  top level clock
rst  in  1  reset, asynchronous, active-high
ld_start  in  1  first beat of a sequence
ld_inc  in  1  middle beat
ld_end  in  1  last beat; commits the sequence
rs1_in  in  XLEN  beat low half
rs2_in  in  XLEN  beat high half
ld_ready  out  1  a free fill bank exists (queue count < 2)
eng_valid  out  1  committed operand set available
eng_ready  in  1  engine accepts the head set
eng_data  out  NBEATS*2*XLEN  head bank; beat k at [k*2*XLEN +: 2*XLEN]
eng_nbeats  out  IDXW  beats in the head set (2..NBEATS)
err_seq  out  1  sticky sequence error
err_ovf  out  1  sticky beat-overflow error
err_clr  in  1  clears both sticky errors

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: all banks 0; queue count, wr_ptr, rd_ptr and idx 0; loader in IDLE; ld_ready 1; eng_valid 0; eng_data 0; eng_nbeats 0; err_seq 0; err_ovf 0.
- Reset asserted mid-sequence or mid-handshake discards everything; there is no partial commit.
- Loader FSM has two states, IDLE and LOADING. The fill bank is always bank[wr_ptr].
- Illegal combination: more than one of ld_start/ld_inc/ld_end in the same cycle sets err_seq. No write, no state change.
- ld_start with count < 2:
  - bank[wr_ptr] is cleared, beat 0 is written, idx <= 1, state -> LOADING.
  - In LOADING, ld_start restarts the sequence (same bank, recleared). This is not an error.
- ld_start with count == 2: dropped, err_seq set.
- ld_inc or ld_end in IDLE: dropped, err_seq set.
- ld_inc in LOADING:
  - idx < NBEATS: write beat idx, idx <= idx+1.
  - idx == NBEATS: dropped, err_ovf set, stays LOADING.
- ld_end in LOADING:
  - idx < NBEATS: write beat idx, nbeats[wr_ptr] <= idx+1, commit (wr_ptr toggles, count+1), idx <= 0, state -> IDLE.
  - idx == NBEATS: data dropped, err_ovf set, sequence aborted (no commit), state -> IDLE.
- Unwritten beats of a committed bank read as 0.
- Commit latency: ld_end sampled at edge T gives eng_valid=1 in the cycle after T. No combinational path from ld_* to eng_*.
- Handshake:
  - eng_valid = (count != 0). eng_data and eng_nbeats come from bank[rd_ptr].
  - Pop on eng_valid & eng_ready: rd_ptr toggles, count-1.
  - eng_data/eng_nbeats stay stable while eng_valid & !eng_ready.
- Commit and pop in the same cycle: count unchanged, both pointers toggle.
- ld_ready = (count < 2), registered-state derived. A pop in cycle T does not enable a start in the same cycle T.
- Error flags: err_clr clears both flags. If err_clr and a new error event occur in the same cycle, the flag is set.
- Full queue: while count == 2 and IDLE, the only legal loader action is waiting. The engine draining an entry raises ld_ready the next cycle.

Decomposition:
- Shared package el2_pkg gets:
  - typedef el2_opbuf_beat_t (2*XLEN logic)
  - OPBUF_NBANK = 2 constant
  - enum el2_opbuf_state_t {IDLE, LOADING}
- One sub-module, el2_exu_custom_opbank:
  - Contents: a single bank of NBEATS beats plus its nbeats register.
  - Inputs: clr, wr_en, wr_idx, wr_data, commit_nbeats.
  - Instantiated twice.
  - The top holds the FSM, pointers, count and error logic.

Test Plan:
- Basic load: start(rs1=0x11,rs2=0x22), inc(0x33,0x44), end(0x55,0x66), eng_ready=1 -> eng_valid 1 cycle after end; eng_nbeats=3; beat0=0x00000022_00000011, beat2=0x00000066_00000055, beats3..6=0; popped next cycle.
- Double buffer: two full sequences with eng_ready=0 -> count=2, ld_ready=0; third ld_start dropped, err_seq=1; raise eng_ready -> first set, then second set, in order; ld_ready=1 the cycle after the first pop.
- Overflow: start + 6 incs (idx=7), 7th inc -> err_ovf=1, no write; then ld_end -> no commit, eng_valid stays 0, state IDLE.
- Sequence errors: ld_inc in IDLE -> err_seq=1; ld_start&ld_end same cycle -> err_seq, idx unchanged; err_clr with a new error the same cycle -> err_seq stays 1.
- Restart and concurrency: start, inc, start(0xAA,0xBB), end -> nbeats=2, beat0=0x..BB_..AA, beat1=end data; commit coincident with pop on count=1 -> count stays 1.
- Reset mid-sequence: assert rst after start+inc with one set queued -> eng_valid=0, ld_ready=1, errors 0; new sequence after reset commits normally.

Source files
------------

// File: rtl/el2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : el2_pkg
// Description : Shared types and constants for the EXU custom operand buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package el2_pkg;

    localparam int OPBUF_XLEN  = 32;
    localparam int OPBUF_NBANK = 2;

    typedef logic [2*OPBUF_XLEN-1:0] el2_opbuf_beat_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        LOADING = 1'b1
    } el2_opbuf_state_t;

endpackage
`default_nettype wire

// File: rtl/el2_exu_custom_opbank.sv
`default_nettype none
// ============================================================================
// Module      : el2_exu_custom_opbank
// Description : One operand bank of NBEATS beats plus its committed beat count.
// Revision    : 1.0 - initial release
// ============================================================================
module el2_exu_custom_opbank #(
    parameter int XLEN   = 32,
    parameter int NBEATS = 7,
    parameter int IDXW   = $clog2(NBEATS+1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [IDXW-1:0]          wr_idx,
    input  logic [2*XLEN-1:0]        wr_data,
    input  logic                     commit,
    input  logic [IDXW-1:0]          commit_nbeats,
    output logic [NBEATS*2*XLEN-1:0] data,
    output logic [IDXW-1:0]          nbeats
);

    localparam int BW = 2*XLEN;

    logic [NBEATS*BW-1:0] r_data;
    logic [IDXW-1:0]      r_nbeats;

    // Beat storage: a clear wipes every beat, a write in the same cycle
    // lands on top of the clear so beat 0 of a fresh sequence survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else begin
            for (int k = 0; k < NBEATS; k++) begin
                if (clr) begin
                    r_data[k*BW +: BW] <= '0;
                end
                if (wr_en && (wr_idx == IDXW'(k))) begin
                    r_data[k*BW +: BW] <= wr_data;
                end
            end
        end
    end

    // Beat count of the set, captured at commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nbeats <= '0;
        end else if (commit) begin
            r_nbeats <= commit_nbeats;
        end
    end

    assign data   = r_data;
    assign nbeats = r_nbeats;

endmodule
`default_nettype wire

// File: rtl/el2_exu_custom_opbuf.sv
`default_nettype none
// ============================================================================
// Module      : el2_exu_custom_opbuf
// Description : Double-buffered multi-beat operand loader feeding a 2-entry
//               queue towards the custom compute engine.
// Revision    : 1.0 - initial release
// ============================================================================
module el2_exu_custom_opbuf
    import el2_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NBEATS = 7,
    parameter int IDXW   = $clog2(NBEATS+1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_start,
    input  logic                     ld_inc,
    input  logic                     ld_end,
    input  logic [XLEN-1:0]          rs1_in,
    input  logic [XLEN-1:0]          rs2_in,
    output logic                     ld_ready,
    output logic                     eng_valid,
    input  logic                     eng_ready,
    output logic [NBEATS*2*XLEN-1:0] eng_data,
    output logic [IDXW-1:0]          eng_nbeats,
    output logic                     err_seq,
    output logic                     err_ovf,
    input  logic                     err_clr
);

    localparam int DW = NBEATS*2*XLEN;

    el2_opbuf_state_t r_state, w_state_nxt;
    logic [IDXW-1:0]  r_idx, w_idx_nxt, w_wr_idx;
    logic             r_wr_ptr, r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_err_seq, r_err_ovf;

    logic             w_multi, w_room, w_idx_full;
    logic             w_start, w_wr_en, w_commit, w_pop, w_seq_ev, w_ovf_ev;

    logic [DW-1:0]    w_bank_data   [OPBUF_NBANK];
    logic [IDXW-1:0]  w_bank_nbeats [OPBUF_NBANK];

    assign w_multi    = (ld_start & ld_inc) | (ld_start & ld_end) | (ld_inc & ld_end);
    assign w_room     = (r_count < 2'd2);
    assign w_idx_full = (r_idx == IDXW'(NBEATS));
    assign w_pop      = (r_count != 2'd0) & eng_ready;

    // Loader decode: next state, bank write controls and error events.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wr_idx    = r_idx;
        w_start     = 1'b0;
        w_wr_en     = 1'b0;
        w_commit    = 1'b0;
        w_seq_ev    = 1'b0;
        w_ovf_ev    = 1'b0;
        if (w_multi) begin
            w_seq_ev = 1'b1;
        end else if (ld_start) begin
            if (w_room) begin
                w_start     = 1'b1;
                w_wr_en     = 1'b1;
                w_wr_idx    = '0;
                w_idx_nxt   = IDXW'(1);
                w_state_nxt = LOADING;
            end else begin
                w_seq_ev = 1'b1;
            end
        end else if (ld_inc) begin
            if (r_state == IDLE) begin
                w_seq_ev = 1'b1;
            end else if (w_idx_full) begin
                w_ovf_ev = 1'b1;
            end else begin
                w_wr_en   = 1'b1;
                w_idx_nxt = r_idx + IDXW'(1);
            end
        end else if (ld_end) begin
            if (r_state == IDLE) begin
                w_seq_ev = 1'b1;
            end else begin
                // Either a commit or an aborted overflowing sequence: both
                // return the loader to IDLE with a fresh index.
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
                if (w_idx_full) begin
                    w_ovf_ev = 1'b1;
                end else begin
                    w_wr_en  = 1'b1;
                    w_commit = 1'b1;
                end
            end
        end
    end

    // Loader state and beat index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Queue pointers and occupancy; commit and pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_commit) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_commit, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky errors; a new event wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_seq <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_seq_ev) begin
                r_err_seq <= 1'b1;
            end else if (err_clr) begin
                r_err_seq <= 1'b0;
            end
            if (w_ovf_ev) begin
                r_err_ovf <= 1'b1;
            end else if (err_clr) begin
                r_err_ovf <= 1'b0;
            end
        end
    end

    generate
        for (genvar b = 0; b < OPBUF_NBANK; b++) begin : g_bank
            logic w_sel;
            assign w_sel = (r_wr_ptr == 1'(b));
            el2_exu_custom_opbank #(
                .XLEN   (XLEN),
                .NBEATS (NBEATS),
                .IDXW   (IDXW)
            ) u_bank (
                .clk           (clk),
                .rst           (rst),
                .clr           (w_start & w_sel),
                .wr_en         (w_wr_en & w_sel),
                .wr_idx        (w_wr_idx),
                .wr_data       ({rs2_in, rs1_in}),
                .commit        (w_commit & w_sel),
                .commit_nbeats (r_idx + IDXW'(1)),
                .data          (w_bank_data[b]),
                .nbeats        (w_bank_nbeats[b])
            );
        end
    endgenerate

    assign ld_ready   = w_room;
    assign eng_valid  = (r_count != 2'd0);
    assign eng_data   = w_bank_data[r_rd_ptr];
    assign eng_nbeats = w_bank_nbeats[r_rd_ptr];
    assign err_seq    = r_err_seq;
    assign err_ovf    = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_el2_exu_custom_opbuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_el2_exu_custom_opbuf
// Description : Self-checking bench for el2_exu_custom_opbuf against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_el2_exu_custom_opbuf;

    localparam int XLEN   = 32;
    localparam int NBEATS = 7;
    localparam int IDXW   = 3;
    localparam int W      = 2*XLEN;
    localparam int BW     = NBEATS*W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ld_start = 1'b0, ld_inc = 1'b0, ld_end = 1'b0;
    logic [XLEN-1:0] rs1_in = '0, rs2_in = '0;
    logic            ld_ready, eng_valid, err_seq, err_ovf;
    logic            eng_ready = 1'b0, err_clr = 1'b0;
    logic [BW-1:0]   eng_data;
    logic [IDXW-1:0] eng_nbeats;

    int n_checks = 0;
    int n_fail   = 0;

    el2_exu_custom_opbuf #(.XLEN(XLEN), .NBEATS(NBEATS), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst),
        .ld_start(ld_start), .ld_inc(ld_inc), .ld_end(ld_end),
        .rs1_in(rs1_in), .rs2_in(rs2_in),
        .ld_ready(ld_ready), .eng_valid(eng_valid), .eng_ready(eng_ready),
        .eng_data(eng_data), .eng_nbeats(eng_nbeats),
        .err_seq(err_seq), .err_ovf(err_ovf), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [BW-1:0] data;
        int            nb;
    } set_t;

    set_t          q[$];
    bit            m_load;
    int            m_idx;
    logic [BW-1:0] m_cur;
    bit            m_eseq, m_eovf;

    function automatic void model_reset();
        q.delete();
        m_load = 0; m_idx = 0; m_cur = '0; m_eseq = 0; m_eovf = 0;
    endfunction

    function automatic void model_step(bit s, bit i, bit e, logic [W-1:0] d, bit rdy, bit clr);
        bit   pop    = (q.size() > 0) && rdy;
        bit   seq    = 0;
        bit   ovf    = 0;
        bit   commit = 0;
        set_t ns;
        if (int'(s) + int'(i) + int'(e) > 1) begin
            seq = 1;
        end else if (s) begin
            if (q.size() < 2) begin
                m_cur = '0; m_cur[0 +: W] = d; m_idx = 1; m_load = 1;
            end else seq = 1;
        end else if (i) begin
            if (!m_load) seq = 1;
            else if (m_idx < NBEATS) begin m_cur[m_idx*W +: W] = d; m_idx++; end
            else ovf = 1;
        end else if (e) begin
            if (!m_load) seq = 1;
            else begin
                if (m_idx < NBEATS) begin
                    m_cur[m_idx*W +: W] = d;
                    ns.data = m_cur; ns.nb = m_idx + 1; commit = 1;
                end else ovf = 1;
                m_load = 0; m_idx = 0;
            end
        end
        if (pop) void'(q.pop_front());
        if (commit) q.push_back(ns);
        m_eseq = seq ? 1'b1 : (clr ? 1'b0 : m_eseq);
        m_eovf = ovf ? 1'b1 : (clr ? 1'b0 : m_eovf);
    endfunction

    // Drive one cycle of stimulus, advance the model at the edge, settle.
    task automatic step(input bit s, input bit i, input bit e,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input bit rdy, input bit clr);
        ld_start = s; ld_inc = i; ld_end = e; rs1_in = a; rs2_in = b;
        eng_ready = rdy; err_clr = clr;
        @(posedge clk);
        model_step(s, i, e, {b, a}, rdy, clr);
        #1;
    endtask

    function automatic logic [W-1:0] beat(input logic [BW-1:0] v, input int k);
        return v[k*W +: W];
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
        n_checks++; if (eng_valid !== 1'b0) begin n_fail++; $display("FAIL reset_eng_valid got %b want 0", eng_valid); end
        n_checks++; if (eng_data !== '0) begin n_fail++; $display("FAIL reset_eng_data got %h want 0", eng_data); end
        n_checks++; if (eng_nbeats !== '0) begin n_fail++; $display("FAIL reset_eng_nbeats got %0d want 0", eng_nbeats); end
        n_checks++; if ({err_seq, err_ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_errs got %b want 00", {err_seq, err_ovf}); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        step(1, 0, 0, 32'h11, 32'h22, 1, 0);
        step(0, 1, 0, 32'h33, 32'h44, 1, 0);
        n_checks++; if (eng_valid !== 1'b0) begin n_fail++; $display("FAIL basic_not_yet_valid got %b want 0", eng_valid); end
        step(0, 0, 1, 32'h55, 32'h66, 1, 0);
        n_checks++; if (eng_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", eng_valid); end
        n_checks++; if (eng_nbeats !== 3'd3) begin n_fail++; $display("FAIL basic_nbeats got %0d want 3", eng_nbeats); end
        n_checks++; if (beat(eng_data, 0) !== 64'h00000022_00000011) begin n_fail++; $display("FAIL basic_beat0 got %h want 0000002200000011", beat(eng_data, 0)); end
        n_checks++; if (beat(eng_data, 1) !== 64'h00000044_00000033) begin n_fail++; $display("FAIL basic_beat1 got %h want 0000004400000033", beat(eng_data, 1)); end
        n_checks++; if (beat(eng_data, 2) !== 64'h00000066_00000055) begin n_fail++; $display("FAIL basic_beat2 got %h want 0000006600000055", beat(eng_data, 2)); end
        n_checks++; if (eng_data[BW-1:3*W] !== '0) begin n_fail++; $display("FAIL basic_upper_beats got %h want 0", eng_data[BW-1:3*W]); end
        step(0, 0, 0, 0, 0, 1, 0);
        n_checks++; if (eng_valid !== 1'b0) begin n_fail++; $display("FAIL basic_popped got %b want 0", eng_valid); end
    endtask

    task automatic test_double_buffer();
        set_t first, second;
        step(1, 0, 0, 32'hA1, 32'hB1, 0, 0);
        step(0, 0, 1, 32'hA2, 32'hB2, 0, 0);
        step(1, 0, 0, 32'hC1, 32'hD1, 0, 0);
        step(0, 1, 0, 32'hC2, 32'hD2, 0, 0);
        step(0, 0, 1, 32'hC3, 32'hD3, 0, 0);
        first = q[0]; second = q[1];
        n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL dbuf_full_ld_ready got %b want 0", ld_ready); end
        step(1, 0, 0, 32'hEE, 32'hFF, 0, 0);
        n_checks++; if (err_seq !== 1'b1) begin n_fail++; $display("FAIL dbuf_start_full_err got %b want 1", err_seq); end
        step(0, 0, 0, 0, 0, 0, 1);
        n_checks++; if (eng_data !== first.data || eng_nbeats !== 3'd2) begin n_fail++; $display("FAIL dbuf_head_first got %h/%0d want %h/2", eng_data, eng_nbeats, first.data); end
        // Pop and start in the same cycle: the start still sees a full queue.
        step(1, 0, 0, 32'h77, 32'h88, 1, 0);
        n_checks++; if (err_seq !== 1'b1) begin n_fail++; $display("FAIL dbuf_pop_start_same_cycle got %b want 1", err_seq); end
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL dbuf_ready_after_pop got %b want 1", ld_ready); end
        n_checks++; if (eng_data !== second.data || eng_nbeats !== 3'd3) begin n_fail++; $display("FAIL dbuf_head_second got %h/%0d want %h/3", eng_data, eng_nbeats, second.data); end
        step(0, 0, 0, 0, 0, 1, 1);
        n_checks++; if (eng_valid !== 1'b0 || err_seq !== 1'b0) begin n_fail++; $display("FAIL dbuf_drained got v=%b e=%b want 0 0", eng_valid, err_seq); end
    endtask

    task automatic test_overflow();
        step(1, 0, 0, 32'h0, 32'h100, 0, 0);
        for (int k = 1; k < NBEATS; k++) step(0, 1, 0, k, 32'h100 + k, 0, 0);
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_full_no_err got %b want 0", err_ovf); end
        step(0, 1, 0, 32'hDEAD, 32'hBEEF, 0, 0);
        n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_inc_err got %b want 1", err_ovf); end
        step(0, 0, 1, 32'hDEAD, 32'hBEEF, 0, 0);
        n_checks++; if (eng_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_end_no_commit got %b want 0", eng_valid); end
        step(0, 1, 0, 0, 0, 0, 0);
        n_checks++; if (err_seq !== 1'b1) begin n_fail++; $display("FAIL ovf_back_to_idle got %b want 1", err_seq); end
        step(0, 0, 0, 0, 0, 0, 1);
        n_checks++; if ({err_seq, err_ovf} !== 2'b00) begin n_fail++; $display("FAIL ovf_clear got %b want 00", {err_seq, err_ovf}); end
    endtask

    task automatic test_seq_errors();
        step(0, 1, 0, 0, 0, 0, 0);
        n_checks++; if (err_seq !== 1'b1) begin n_fail++; $display("FAIL seq_inc_idle got %b want 1", err_seq); end
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 32'h1, 32'h2, 0, 0);
        step(1, 0, 1, 32'h9, 32'h9, 0, 0);
        n_checks++; if (err_seq !== 1'b1 || eng_valid !== 1'b0) begin n_fail++; $display("FAIL seq_multi got e=%b v=%b want 1 0", err_seq, eng_valid); end
        step(0, 1, 1, 32'h9, 32'h9, 0, 1);
        n_checks++; if (err_seq !== 1'b1) begin n_fail++; $display("FAIL seq_clr_vs_new got %b want 1", err_seq); end
        step(0, 0, 1, 32'h3, 32'h4, 1, 1);
        n_checks++; if (eng_nbeats !== 3'd2 || beat(eng_data, 1) !== 64'h00000004_00000003) begin n_fail++; $display("FAIL seq_idx_kept got %0d/%h want 2/0000000400000003", eng_nbeats, beat(eng_data, 1)); end
        n_checks++; if (err_seq !== 1'b0) begin n_fail++; $display("FAIL seq_cleared got %b want 0", err_seq); end
        step(0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_restart_concurrency();
        step(1, 0, 0, 32'h1, 32'h2, 0, 0);
        step(0, 1, 0, 32'h3, 32'h4, 0, 0);
        step(1, 0, 0, 32'hAA, 32'hBB, 0, 0);
        step(0, 0, 1, 32'hCC, 32'hDD, 0, 0);
        n_checks++; if (eng_nbeats !== 3'd2) begin n_fail++; $display("FAIL restart_nbeats got %0d want 2", eng_nbeats); end
        n_checks++; if (eng_data !== {{(BW-2*W){1'b0}}, 64'h000000DD_000000CC, 64'h000000BB_000000AA}) begin n_fail++; $display("FAIL restart_data got %h", eng_data); end
        step(1, 0, 0, 32'h5, 32'h6, 0, 0);
        step(0, 0, 1, 32'h7, 32'h8, 1, 0);
        n_checks++; if (eng_valid !== 1'b1 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL conc_count_one got v=%b r=%b want 1 1", eng_valid, ld_ready); end
        n_checks++; if (eng_data !== q[0].data || beat(eng_data, 0) !== 64'h00000006_00000005) begin n_fail++; $display("FAIL conc_head got %h want %h", eng_data, q[0].data); end
        step(0, 0, 0, 0, 0, 1, 0);
        n_checks++; if (eng_valid !== 1'b0) begin n_fail++; $display("FAIL conc_drain got %b want 0", eng_valid); end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 32'h1, 32'h1, 0, 0);
        step(0, 0, 1, 32'h2, 32'h2, 0, 0);
        step(1, 0, 0, 32'h3, 32'h3, 0, 0);
        step(0, 1, 0, 32'h4, 32'h4, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        ld_start = 0; ld_inc = 0; ld_end = 0;
        #2 rst = 1'b1; model_reset();
        #1;
        n_checks++; if (eng_valid !== 1'b0 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_queue got v=%b r=%b want 0 1", eng_valid, ld_ready); end
        n_checks++; if ({err_seq, err_ovf} !== 2'b00) begin n_fail++; $display("FAIL rstmid_errs got %b want 00", {err_seq, err_ovf}); end
        @(posedge clk); #1 rst = 1'b0;
        step(0, 0, 1, 0, 0, 0, 0);
        n_checks++; if (err_seq !== 1'b1 || eng_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got e=%b v=%b want 1 0", err_seq, eng_valid); end
        step(1, 0, 0, 32'h9A, 32'h9B, 0, 1);
        step(0, 0, 1, 32'h9C, 32'h9D, 0, 0);
        n_checks++; if (eng_valid !== 1'b1 || eng_nbeats !== 3'd2 || beat(eng_data, 0) !== 64'h0000009B_0000009A) begin n_fail++; $display("FAIL rstmid_recommit got v=%b n=%0d b0=%h", eng_valid, eng_nbeats, beat(eng_data, 0)); end
        step(0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            int  op = $urandom_range(0, 19);
            bit  s  = (op <= 3) || (op == 16);
            bit  i  = (op >= 4 && op <= 11) || (op == 16 && $urandom_range(0, 1) == 1);
            bit  e  = (op >= 12 && op <= 15) || (op == 16 && !i);
            step(s, i, e, $urandom, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            n_checks++; if (eng_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, eng_valid, q.size() != 0); end
            n_checks++; if (ld_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ld_ready cyc %0d got %b want %b", c, ld_ready, q.size() < 2); end
            n_checks++; if ({err_seq, err_ovf} !== {m_eseq, m_eovf}) begin n_fail++; $display("FAIL rnd_errs cyc %0d got %b want %b", c, {err_seq, err_ovf}, {m_eseq, m_eovf}); end
            if (q.size() != 0) begin
                n_checks++; if (eng_data !== q[0].data) begin n_fail++; $display("FAIL rnd_data cyc %0d got %h want %h", c, eng_data, q[0].data); end
                n_checks++; if (eng_nbeats !== IDXW'(q[0].nb)) begin n_fail++; $display("FAIL rnd_nbeats cyc %0d got %0d want %0d", c, eng_nbeats, q[0].nb); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_double_buffer();
        test_overflow();
        test_seq_errors();
        test_restart_concurrency();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
